// File: rtl/axi_stream_dma_writer.sv
// AXI3 burst-write DMA: gathers BURST_BEATS stream samples into a local burst buffer, then
// writes them to a linear or ring buffer in DDR, replaying the buffer on error responses.
module axi_stream_dma_writer #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BURST_BEATS = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [31:0] DMA_BYTES   = 32'h0002_0000,
  parameter int unsigned MAX_RETRIES = 2
) (
  input  logic                aclk,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                circular_i,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic [31:0]         m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [3:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic                m_axi_bvalid,
  input  logic [1:0]          m_axi_bresp,
  output logic                m_axi_bready,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [15:0]         wrap_count_o,
  output logic [31:0]         beat_index_o
);
  localparam int unsigned   StrbW      = DATA_W / 8;
  localparam int unsigned   SizeLog    = $clog2(StrbW);
  localparam int unsigned   BeatW      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [31:0]   BurstBytes = 32'(BURST_BEATS * StrbW);
  localparam logic [31:0]   EndAddr    = BASE_ADDR + DMA_BYTES;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_BEATS - 1);
  localparam logic [7:0]    MaxRetries = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {StIdle, StFill, StAddr, StData, StResp, StDone} state_e;

  state_e            state_q, state_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        retry_q, retry_d;
  logic [15:0]       wrap_q, wrap_d;
  logic              stop_q, stop_d;
  logic              circ_q, circ_d;
  logic              err_q, err_d;
  logic              start_q;
  logic [DATA_W-1:0] buf_q [BURST_BEATS];

  logic        start_edge, busy, fill_fire;
  logic [31:0] next_addr;

  assign start_edge = start_i & ~start_q;
  assign busy       = (state_q == StFill) | (state_q == StAddr) |
                      (state_q == StData) | (state_q == StResp);
  assign fill_fire  = (state_q == StFill) & s_valid_i;
  assign next_addr  = addr_q + BurstBytes;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    retry_d = retry_q;
    wrap_d  = wrap_q;
    stop_d  = stop_q | (busy & stop_i);
    circ_d  = circ_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_edge) begin
          state_d = StFill;
          beat_d  = '0;
          addr_d  = BASE_ADDR;
          retry_d = '0;
          wrap_d  = '0;
          stop_d  = 1'b0;
          circ_d  = circular_i;
          err_d   = 1'b0;
        end
      end
      StFill: begin
        if (s_valid_i) begin
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StAddr;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StAddr: begin
        if (m_axi_awready) state_d = StData;
      end
      StData: begin
        if (m_axi_wready) begin
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StResp;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StResp: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp == 2'b00) begin
            retry_d = '0;
            addr_d  = next_addr;
            if (stop_q) begin
              state_d = StDone;
            end else if (next_addr >= EndAddr) begin
              if (circ_q) begin
                addr_d  = BASE_ADDR;
                wrap_d  = (wrap_q == 16'hFFFF) ? wrap_q : wrap_q + 16'd1;
                state_d = StFill;
              end else begin
                state_d = StDone;
              end
            end else begin
              state_d = StFill;
            end
          end else if (retry_q < MaxRetries) begin
            // Buffer still holds the burst, so re-issuing AW replays it unchanged.
            retry_d = retry_q + 8'd1;
            state_d = StAddr;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      state_q <= StIdle;
      beat_q  <= '0;
      addr_q  <= BASE_ADDR;
      retry_q <= '0;
      wrap_q  <= '0;
      stop_q  <= 1'b0;
      circ_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      retry_q <= retry_d;
      wrap_q  <= wrap_d;
      stop_q  <= stop_d;
      circ_q  <= circ_d;
      err_q   <= err_d;
      start_q <= start_i;
    end
  end

  always_ff @(posedge aclk) begin
    if (fill_fire) buf_q[beat_q] <= s_data_i;
  end

  assign s_ready_o     = (state_q == StFill);
  assign m_axi_awvalid = (state_q == StAddr);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 4'(BURST_BEATS - 1);
  assign m_axi_awsize  = 3'(SizeLog);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wvalid  = (state_q == StData);
  assign m_axi_wlast   = (state_q == StData) & (beat_q == LastBeat);
  assign m_axi_wdata   = (state_q == StData) ? buf_q[beat_q] : '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = (state_q == StResp);
  assign busy_o        = busy;
  assign done_o        = (state_q == StDone);
  assign error_o       = err_q;
  assign wrap_count_o  = wrap_q;
  assign beat_index_o  = ((addr_q - BASE_ADDR) >> SizeLog) + 32'(beat_q);
endmodule
